// File: rtl/wb_ibn_loader_if.sv
// Wishbone classic bus bundle between the Caravel management initiator and wb_ibn_loader.
interface wb_ibn_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_ibn_loader.sv
// Wishbone responder that loads the ibnalhaytham instruction memory and controls core reset/run.
// Define WB_IBN_TIMEOUT_EN to bound the imem write wait to TIMEOUT cycles and flag err.
module wb_ibn_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned IMEM_AW   = 10,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    wb_ibn_loader_if.slave     wbs,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic [3:0]         imem_wmask,
    input  logic               imem_ready,
    output logic               core_rst_n,
    input  logic               core_halted
);

    typedef enum logic [1:0] {StIdle, StAck, StImemWait} state_e;

    localparam logic [2:0] OffCtrl     = 3'd0;
    localparam logic [2:0] OffStatus   = 3'd1;
    localparam logic [2:0] OffImemAddr = 3'd2;
    localparam logic [2:0] OffImemData = 3'd3;
    localparam logic [2:0] OffCycles   = 3'd4;

    state_e             state_q, state_d;
    logic               hold_q, run_q, core_rst_n_q, abort_q;
    logic [IMEM_AW-1:0] iaddr_q, iaddr_wr;
    logic [31:0]        idata_q, cycles_q, rdata_q, rdata;
    logic               ack, busy, err, hit, req, accept, tmo_hit, clr_cycles;
    logic [2:0]         off;
    logic               unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign hit        = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off        = wbs.wbs_adr_i[4:2];
    assign unused_adr = ^{wbs.wbs_adr_i[7:5], wbs.wbs_adr_i[1:0]};
    assign req        = wbs.wbs_stb_i && wbs.wbs_cyc_i && hit && !ack && (state_q == StIdle);
    assign accept     = (state_q == StImemWait) && imem_ready;
    assign clr_cycles = req && wbs.wbs_we_i && (off == OffCtrl) && wbs.wbs_sel_i[0]
                        && wbs.wbs_dat_i[2];
    assign core_rst_n = core_rst_n_q;

    always_comb begin
        iaddr_wr = iaddr_q;
        for (int i = 0; i < IMEM_AW; i++) begin
            if (wbs.wbs_sel_i[i/8]) iaddr_wr[i] = wbs.wbs_dat_i[i];
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OffCtrl:     rdata = {30'd0, run_q, hold_q};
            OffStatus:   rdata = {29'd0, core_halted, err, busy};
            OffImemAddr: rdata = 32'(iaddr_q);
            OffImemData: rdata = idata_q;
            OffCycles:   rdata = cycles_q;
            default:     rdata = '0;
        endcase
    end

`ifdef WB_IBN_TIMEOUT_EN
    localparam int unsigned TmoCntW = $clog2(TIMEOUT + 1);

    logic [TmoCntW-1:0] tmo_cnt_q;
    logic               err_q;

    assign tmo_hit = (state_q == StImemWait) && !imem_ready
                     && (tmo_cnt_q == TmoCntW'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StImemWait) ? tmo_cnt_q + 1'b1 : '0;
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (req && wbs.wbs_we_i && (off == OffStatus) && wbs.wbs_sel_i[0]
                         && wbs.wbs_dat_i[1]) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign tmo_hit        = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (wbs.wbs_we_i && (off == OffImemData)) ? StImemWait : StAck;
                end
            end
            StAck: state_d = StIdle;
            StImemWait: begin
                // An initiator that gave up on the cycle gets its write but no ack.
                if (accept || tmo_hit) begin
                    state_d = (abort_q || !wbs.wbs_cyc_i) ? StIdle : StAck;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack  = 1'b0;
        busy = 1'b0;
        unique case (state_q)
            StAck:      ack  = 1'b1;
            StImemWait: busy = 1'b1;
            default: ;
        endcase
    end

    assign wbs.wbs_ack_o = ack;
    assign wbs.wbs_dat_o = ack ? rdata_q : '0;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            hold_q       <= 1'b1;
            run_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            abort_q      <= 1'b0;
            cycles_q     <= '0;
            iaddr_q      <= '0;
            idata_q      <= '0;
            rdata_q      <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            imem_wmask   <= '0;
        end else begin
            core_rst_n_q <= ~hold_q;
            abort_q      <= (state_q == StImemWait) && (abort_q || !wbs.wbs_cyc_i);
            if (clr_cycles) begin
                cycles_q <= '0;
            end else if (run_q && !hold_q) begin
                cycles_q <= cycles_q + 32'd1;
            end
            if (req) begin
                rdata_q <= wbs.wbs_we_i ? '0 : rdata;
                if (wbs.wbs_we_i) begin
                    case (off)
                        OffCtrl: begin
                            if (wbs.wbs_sel_i[0]) begin
                                hold_q <= wbs.wbs_dat_i[0];
                                run_q  <= wbs.wbs_dat_i[1];
                            end
                        end
                        OffImemAddr: iaddr_q <= iaddr_wr;
                        OffImemData: begin
                            idata_q    <= merge(idata_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
                            imem_we    <= 1'b1;
                            imem_addr  <= iaddr_q;
                            imem_wdata <= wbs.wbs_dat_i;
                            imem_wmask <= wbs.wbs_sel_i;
                        end
                        default: ;
                    endcase
                end
            end
            if (accept) begin
                imem_we <= 1'b0;
                iaddr_q <= iaddr_q + 1'b1;
            end else if (tmo_hit) begin
                imem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_ibn_loader.sv
// Self-checking bench for wb_ibn_loader: register vector table plus multi-cycle imem sequences.
module tb_wb_ibn_loader;

    localparam logic [31:0] Base = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_wmask;
    logic        imem_ready;
    logic        core_rst_n;
    logic        core_halted;

    wb_ibn_loader_if wbs ();

    wb_ibn_loader #(
        .BASE_ADDR (Base),
        .IMEM_AW   (10),
        .TIMEOUT   (64)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .wbs         (wbs),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_wmask  (imem_wmask),
        .imem_ready  (imem_ready),
        .core_rst_n  (core_rst_n),
        .core_halted (core_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  off;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[19];
    logic [31:0] sb_q[$];
    int          nchk = 0;
    int          nerr = 0;

    logic        r_got;
    int          r_lat, r_wec;
    logic [9:0]  r_ia;
    logic [31:0] r_id, r_rd;
    logic [3:0]  r_im;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle, called at a negedge; imem_ready rises once imem_we has been high low_n cycles.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int low_n);
        r_got = 1'b0; r_lat = 0; r_wec = 0; r_ia = '0; r_id = '0; r_im = '0; r_rd = '0;
        wbs.wbs_adr_i = adr;
        wbs.wbs_we_i  = we;
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        while (!r_got && r_lat < 200) begin
            @(negedge clk);
            r_lat++;
            if (imem_we) begin
                if (r_wec == 0) begin
                    r_ia = imem_addr;
                    r_id = imem_wdata;
                    r_im = imem_wmask;
                end
                r_wec++;
                imem_ready = (r_wec > low_n);
            end else begin
                imem_ready = 1'b0;
            end
            if (wbs.wbs_ack_o) begin
                r_got = 1'b1;
                r_rd  = wbs.wbs_dat_o;
            end
        end
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        imem_ready    = 1'b0;
        @(negedge clk);
        chk("ack_single_cycle", {31'd0, wbs.wbs_ack_o}, 32'd0);
    endtask

    function automatic logic [31:0] reg_adr(input logic [2:0] off);
        return Base + {27'd0, off, 2'b00};
    endfunction

    task automatic wr(input logic [2:0] off, input logic [31:0] dat, input logic [3:0] sel);
        xfer(reg_adr(off), 1'b1, dat, sel, 0);
        chk("wr_ack", {31'd0, r_got}, 32'd1);
    endtask

    task automatic rd_chk(input logic [2:0] off, input logic [31:0] exp, input string name);
        logic [31:0] e;
        sb_q.push_back(exp);
        xfer(reg_adr(off), 1'b0, 32'd0, 4'hF, 0);
        e = sb_q.pop_front();
        if (r_got) chk(name, r_rd, e);
        else chk({name, "_ack"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks, wes;
        rst_n = 1'b0;
        imem_ready = 1'b0;
        core_halted = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_dat_i = 32'd0;
        wbs.wbs_adr_i = 32'd0;

        vecs[0]  = '{3'd0, 1'b0, 32'h0,         4'hF, 32'h1,   "ctrl_reset"};
        vecs[1]  = '{3'd1, 1'b0, 32'h0,         4'hF, 32'h0,   "status_reset"};
        vecs[2]  = '{3'd2, 1'b0, 32'h0,         4'hF, 32'h0,   "iaddr_reset"};
        vecs[3]  = '{3'd4, 1'b0, 32'h0,         4'hF, 32'h0,   "cycles_reset"};
        vecs[4]  = '{3'd2, 1'b1, 32'h5,         4'hF, 32'h0,   "iaddr_wr5"};
        vecs[5]  = '{3'd2, 1'b0, 32'h0,         4'hF, 32'h5,   "iaddr_rd5"};
        vecs[6]  = '{3'd2, 1'b1, 32'h300,       4'h2, 32'h0,   "iaddr_wr_byte1"};
        vecs[7]  = '{3'd2, 1'b0, 32'h0,         4'hF, 32'h305, "iaddr_byte_merge"};
        vecs[8]  = '{3'd2, 1'b1, 32'hFFFF_FC05, 4'hF, 32'h0,   "iaddr_wr_wide"};
        vecs[9]  = '{3'd2, 1'b0, 32'h0,         4'hF, 32'h5,   "iaddr_upper_zero"};
        vecs[10] = '{3'd5, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,   "off5_wr"};
        vecs[11] = '{3'd5, 1'b0, 32'h0,         4'hF, 32'h0,   "off5_rd"};
        vecs[12] = '{3'd7, 1'b0, 32'h0,         4'hF, 32'h0,   "off7_rd"};
        vecs[13] = '{3'd0, 1'b1, 32'h0,         4'hE, 32'h0,   "ctrl_wr_nosel0"};
        vecs[14] = '{3'd0, 1'b0, 32'h0,         4'hF, 32'h1,   "ctrl_sel_honoured"};
        vecs[15] = '{3'd0, 1'b1, 32'h5,         4'hF, 32'h0,   "ctrl_wr_clr"};
        vecs[16] = '{3'd0, 1'b0, 32'h0,         4'hF, 32'h1,   "ctrl_clr_reads0"};
        vecs[17] = '{3'd4, 1'b0, 32'h0,         4'hF, 32'h0,   "cycles_held"};
        vecs[18] = '{3'd3, 1'b0, 32'h0,         4'hF, 32'h0,   "idata_reset"};

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs.wbs_dat_o, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_imem_wmask", {28'd0, imem_wmask}, 32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].we) begin
                xfer(reg_adr(vecs[i].off), 1'b1, vecs[i].dat, vecs[i].sel, 0);
            end else begin
                sb_q.push_back(vecs[i].exp);
                xfer(reg_adr(vecs[i].off), 1'b0, 32'd0, vecs[i].sel, 0);
            end
            chk({vecs[i].name, "_ack"}, {31'd0, r_got}, 32'd1);
            chk({vecs[i].name, "_latency"}, r_lat, 32'd1);
            if (!vecs[i].we) chk(vecs[i].name, r_rd, sb_q.pop_front());
        end

        core_halted = 1'b1;
        rd_chk(3'd1, 32'h4, "status_halted");
        core_halted = 1'b0;

        // imem write accepted immediately
        xfer(reg_adr(3'd3), 1'b1, 32'h0000_0093, 4'hF, 0);
        chk("imem1_ack", {31'd0, r_got}, 32'd1);
        chk("imem1_we_cycles", r_wec, 32'd1);
        chk("imem1_addr", {22'd0, r_ia}, 32'd5);
        chk("imem1_wdata", r_id, 32'h93);
        chk("imem1_wmask", {28'd0, r_im}, 32'hF);
        chk("imem1_latency", r_lat, 32'd2);
        rd_chk(3'd2, 32'd6, "imem1_addr_inc");
        rd_chk(3'd3, 32'h93, "imem1_data_rd");

        // ready held low for 3 cycles at the top address
        wr(3'd2, 32'h3FF, 4'hF);
        xfer(reg_adr(3'd3), 1'b1, 32'hDEAD_BEEF, 4'hC, 3);
        chk("imem2_ack", {31'd0, r_got}, 32'd1);
        chk("imem2_we_cycles", r_wec, 32'd4);
        chk("imem2_addr", {22'd0, r_ia}, 32'h3FF);
        chk("imem2_wdata", r_id, 32'hDEAD_BEEF);
        chk("imem2_wmask", {28'd0, r_im}, 32'hC);
        chk("imem2_latency", r_lat, 32'd5);
        rd_chk(3'd2, 32'd0, "imem2_addr_wrap");
        rd_chk(3'd3, 32'hDEAD_0093, "imem2_data_merge");

        // cycle counter: one extra edge per bus call for the idle gap after ack
        wr(3'd0, 32'h2, 4'hF);
        repeat (100) @(negedge clk);
        chk("core_rst_n_run", {31'd0, core_rst_n}, 32'd1);
        rd_chk(3'd4, 32'd101, "cycles_100");
        wr(3'd0, 32'h6, 4'hF);
        rd_chk(3'd4, 32'd1, "cycles_cleared");
        rd_chk(3'd0, 32'h2, "ctrl_run");
        chk("core_rst_n_after_clr", {31'd0, core_rst_n}, 32'd1);

        // unmapped addresses
        acks = 0; wes = 0;
        wbs.wbs_adr_i = Base + 32'h100;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'hF;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) acks++;
        end
        wbs.wbs_adr_i = Base + 32'h10C;
        wbs.wbs_we_i  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) acks++;
            if (imem_we) wes++;
        end
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        @(negedge clk);
        chk("unmapped_no_ack", acks, 32'd0);
        chk("unmapped_no_imem_we", wes, 32'd0);

        // initiator drops cyc while the write waits
        wr(3'd2, 32'd7, 4'hF);
        wbs.wbs_adr_i = reg_adr(3'd3);
        wbs.wbs_dat_i = 32'h13;
        wbs.wbs_sel_i = 4'hF;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        repeat (2) @(negedge clk);
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        @(negedge clk);
        chk("drop_still_waiting", {31'd0, imem_we}, 32'd1);
        imem_ready = 1'b1;
        acks = 0;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("drop_we_cleared", {31'd0, imem_we}, 32'd0);
        if (wbs.wbs_ack_o) acks++;
        repeat (3) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) acks++;
        end
        chk("drop_no_ack", acks, 32'd0);
        rd_chk(3'd2, 32'd8, "drop_addr_inc");
        rd_chk(3'd3, 32'h13, "drop_data");

        wr(3'd2, 32'd20, 4'hF);
`ifdef WB_IBN_TIMEOUT_EN
        xfer(reg_adr(3'd3), 1'b1, 32'h33, 4'hF, 100000);
        chk("tmo_ack", {31'd0, r_got}, 32'd1);
        chk("tmo_we_cycles", r_wec, 32'd64);
        chk("tmo_latency", r_lat, 32'd65);
        rd_chk(3'd1, 32'h2, "tmo_status_err");
        rd_chk(3'd2, 32'd20, "tmo_addr_kept");
        wr(3'd1, 32'h2, 4'h1);
        rd_chk(3'd1, 32'h0, "tmo_err_cleared");
`else
        xfer(reg_adr(3'd3), 1'b1, 32'h33, 4'hF, 80);
        chk("wait_ack", {31'd0, r_got}, 32'd1);
        chk("wait_we_cycles", r_wec, 32'd81);
        chk("wait_latency", r_lat, 32'd82);
        rd_chk(3'd1, 32'h0, "wait_no_err");
        rd_chk(3'd2, 32'd21, "wait_addr_inc");
`endif

        // reset asserted while the write waits
        wr(3'd2, 32'd9, 4'hF);
        wbs.wbs_adr_i = reg_adr(3'd3);
        wbs.wbs_dat_i = 32'h55;
        wbs.wbs_sel_i = 4'hF;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstw_waiting", {31'd0, imem_we}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_we_dropped", {31'd0, imem_we}, 32'd0);
        chk("rstw_no_ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) acks++;
        end
        chk("rstw_no_ack_held", acks, 32'd0);
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        rd_chk(3'd2, 32'd0, "rstw_iaddr");
        rd_chk(3'd0, 32'h1, "rstw_ctrl");
        rd_chk(3'd4, 32'd0, "rstw_cycles");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/wb_ibn_loader.md
Name: wb_ibn_loader

Overview:
- Wishbone classic responder (slave) on the Caravel management bus; the Caravel CPU is the initiator.
- Lets firmware load the ibnalhaytham RV32I instruction memory word by word.
- Holds the core in reset, starts it, and exposes a run-cycle counter.
- Sits beside the core inside the user-project wrapper. Its outputs pass through the wrapper's `active` tristate like every other output.

Parameters:
- BASE_ADDR, 32'h3000_0000, responder base; decode compares wbs_adr_i[31:8] with BASE_ADDR[31:8].
- IMEM_AW, 10, instruction-memory word-address width.
- TIMEOUT, 64, max cycles to wait for imem_ready (optional feature only).

Ports:
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_n  in  1  synchronous active-low reset
- wbs_stb_i  in  1  wishbone strobe
- wbs_cyc_i  in  1  wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge, single-cycle pulse
- wbs_dat_o  out  32  read data, valid with ack
- imem_we  out  1  instruction-memory write request
- imem_addr  out  IMEM_AW  word address
- imem_wdata  out  32  write data
- imem_wmask  out  4  byte mask (copy of wbs_sel_i)
- imem_ready  in  1  memory accepts a write when imem_we && imem_ready
- core_rst_n  out  1  core reset, active low
- core_halted  in  1  core status flag, read-only visibility

Behaviour:
- Reset: sync, active low, checked at the clock edge. Values on reset:
  - wbs_ack_o=0, wbs_dat_o=0, imem_we=0, imem_addr=0, imem_wdata=0, imem_wmask=0
  - core_rst_n=0 (hold=1), run=0, CYCLES=0, err=0, state=IDLE
- Reset mid-transaction: abandons any pending imem write (imem_we drops next edge) and issues no ack.
- Request definition: stb&&cyc&&hit&&!wbs_ack_o in state IDLE. Unselected addresses are never acked.
- Register map, word offset adr[4:2]:
  - 0 CTRL rw: bit0 hold (reset 1); bit1 run (reset 0); bit2 clr_cycles (self-clearing, reads 0).
  - 1 STATUS ro: bit0 busy; bit1 err (sticky; cleared by writing STATUS with bit1=1); bit2 core_halted.
  - 2 IMEM_ADDR rw: [IMEM_AW-1:0]; upper bits read 0.
  - 3 IMEM_DATA: write issues an imem write; read returns the last written data.
  - 4 CYCLES ro: increments when run&&!hold, wraps 32'hFFFF_FFFF->0. clr_cycles wins over the increment in the same cycle.
  - 5-7: read 0, writes ignored, acked normally.
- Register writes honour wbs_sel_i per byte. core_rst_n = ~hold, registered.
- FSM states IDLE, ACK, IMEM_WAIT:
  - IDLE -> ACK on any request except an IMEM_DATA write. The register write or read takes effect at that edge.
  - ACK: wbs_ack_o=1 for exactly one cycle, wbs_dat_o valid, then IDLE.
  - IDLE -> IMEM_WAIT on an IMEM_DATA write. imem_we=1 from the next cycle, with imem_addr=IMEM_ADDR, imem_wdata=wbs_dat_i, imem_wmask=wbs_sel_i. busy=1.
  - IMEM_WAIT -> ACK at the first edge with imem_ready=1. That edge sets imem_we=0 and increments IMEM_ADDR modulo 2^IMEM_AW (wraps to 0).
  - Latency: register access ack one cycle after request; imem write ack one cycle after acceptance.
- Master drops cyc during IMEM_WAIT: the write still completes, no ack is issued, FSM returns to IDLE.
- Back-to-back requests are allowed; a new request is recognised in the cycle after the ack.
- wbs_dat_o returns 0 outside ACK.

Optional Feature:
- Macro: WB_IBN_TIMEOUT_EN.
- Defined: a counter runs in IMEM_WAIT. If TIMEOUT cycles pass without imem_ready:
  - imem_we drops, err is set, the wishbone cycle is acked anyway;
  - IMEM_ADDR is not incremented.
- Undefined: IMEM_WAIT waits indefinitely, err is never set, STATUS bit1 reads 0.

Test Plan:
- Reset, then read CTRL at offset 0x00 -> ack one cycle after request, data 32'h1; core_rst_n=0.
- Write IMEM_ADDR=5, then IMEM_DATA=32'h0000_0093 with imem_ready held 1:
  - imem_we pulses 1 cycle with imem_addr=5;
  - ack follows; IMEM_ADDR reads 6.
- Write IMEM_ADDR=2^IMEM_AW-1, then IMEM_DATA with imem_ready low for 3 cycles:
  - imem_we stays 1 for 4 cycles; ack is 1 cycle after acceptance;
  - busy=1 while waiting; IMEM_ADDR wraps to 0.
- Write CTRL=32'h2 (hold=0, run=1), wait 100 cycles, read CYCLES -> approx 100 (exact vs. bench count). Then:
  - write CTRL=32'h6 -> CYCLES reads small, near 0;
  - core_rst_n=1.
- Access BASE_ADDR+32'h100 -> no ack ever; assert wb_rst_n=0 during IMEM_WAIT -> imem_we=0 and no ack next cycle.
- With WB_IBN_TIMEOUT_EN, keep imem_ready=0 -> ack after TIMEOUT cycles, STATUS=32'h2, IMEM_ADDR unchanged. Write STATUS=32'h2 -> err clears.
